panel_input_ctrl: RTL and testbench
===================================

# panel_input_ctrl

Front-panel input controller between the board switches/buttons and the CPU subsystem's PIO inputs. Synchronizes and debounces the raw panel controls. Turns button presses into edits of a 6-digit hex value with a digit cursor, and hands committed values to the CPU side over a valid/ready handshake. Also generates the "step" pulses that pace processing, either from the continue button in manual mode or from an internal timer in auto mode.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a debounced level changes (≥2)
- AUTO_PERIOD, 50000000, cycles between step pulses in auto mode (≥2)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- auto_manual  in  1  raw switch; 1 = auto stepping, 0 = manual
- continue0  in  1  raw button, active-high; manual step request
- left_right  in  2  raw buttons, active-high; [1] = left, [0] = right
- up_down  in  2  raw buttons, active-high; [1] = up, [0] = down
- set_value  in  1  raw button, active-high; commit current edit value
- edit_value  out  24  value being edited, digit k = bits [4k+3:4k]
- cursor  out  3  selected digit index 0..5, 0 = least significant
- commit_valid  out  1  committed value available
- commit_data  out  24  committed value, stable while commit_valid=1
- commit_ready  in  1  consumer accepts commit_data
- step  out  1  one-cycle step pulse

## Operation
- Every raw input (7 bits) passes a 2-FF synchronizer, then a per-bit debouncer.
  - Each bit has a counter that increments while the synchronized level differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- A press is a registered one-cycle pulse on the rising edge of a debounced level. Releases generate nothing.
- Cursor:
  - left press: cursor+1, with 5→0 wrap.
  - right press: cursor−1, with 0→5 wrap.
  - left and right pressed in the same cycle: no change.
- Digit edit:
  - up press: digit[cursor]+1 mod 16.
  - down press: digit[cursor]−1 mod 16.
  - up and down pressed in the same cycle: no change.
  - Other digits are never touched.
  - A cursor move and a digit edit in the same cycle use the old cursor for the edit.
- Commit FSM, states IDLE and PEND:
  - IDLE: a set_value press loads commit_data with edit_value as it was before any same-cycle edit, sets commit_valid=1 and moves to PEND.
  - PEND: commit_valid and commit_data are held. On an edge with commit_valid&commit_ready, commit_valid clears and the FSM returns to IDLE.
  - set_value presses in PEND are dropped.
  - Edits to edit_value continue in PEND without affecting commit_data.
- Step generation:
  - Manual (debounced auto_manual=0): each continue0 press produces one step pulse.
  - Auto (debounced auto_manual=1): a period counter runs 0..AUTO_PERIOD−1 and step pulses when it reaches AUTO_PERIOD−1, then the counter wraps to 0. continue0 presses are ignored.
  - Any change of debounced auto_manual clears the period counter, so the first auto step follows AUTO_PERIOD cycles after entering auto.

## Timing
- Reset (async assert, sync-safe deassert by the system) sets every output and internal register to 0:
  - edit_value=0, cursor=0, commit_valid=0, commit_data=0, step=0.
  - Debounced levels, counters and FSM go to IDLE/0.
  - Reset during PEND drops the pending commit.
- Press latency, with a raw input rising and held from edge 0:
  - Debounced level is 1 after edge DEBOUNCE_CYCLES+1.
  - Press pulse is high during the cycle after edge DEBOUNCE_CYCLES+2.
  - The action (cursor, edit_value, commit_valid, step) is visible after edge DEBOUNCE_CYCLES+3.
- Bounce: a raw level held for fewer than DEBOUNCE_CYCLES synchronized cycles produces no press.
- Handshake: commit_ready may be held high permanently. The transfer completes on the first edge with valid&ready, and commit_valid is low after that edge. The minimum PEND duration is 1 cycle.
- step is never high for two consecutive cycles.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, AUTO_PERIOD=10.
- Debounce: up_down[1] high for 3 cycles, then low → edit_value stays 0x000000. High for 12 cycles → edit_value=0x000001 exactly 7 cycles after the first high sample, and only one increment.
- Wrap: from reset, press right → cursor=5. Press up twice → edit_value=0x200000. Press left → cursor=0. Press down 3 times → edit_value=0x20000D.
- Simultaneous: up and down together → no change; left and right together → cursor unchanged.
- Commit with edit_value=0x20000D and commit_ready=0:
  - Press set_value → commit_valid=1, commit_data=0x20000D.
  - Press up → edit_value=0x20000E, commit_data unchanged.
  - Second set_value press is dropped.
  - Raise commit_ready → commit_valid=0 after one edge.
- Stepping:
  - auto_manual=1 → step pulses exactly every 10 cycles; continue0 presses add no pulses.
  - Switch to 0 → no more timer steps; each continue0 press → exactly one step pulse.
- Reset mid-operation: assert reset while in PEND with cursor=3 → all outputs 0 immediately (before the next edge). After release, set_value → commit_data=0x000000.

Source files
------------

// File: rtl/panel_input_ctrl.sv
// Front-panel input controller: synchronizes and debounces panel controls, edits a
// 6-digit hex value under a cursor, commits it over valid/ready and paces step pulses.
module panel_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_PERIOD     = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        auto_manual,
  input  logic        continue0,
  input  logic [1:0]  left_right,
  input  logic [1:0]  up_down,
  input  logic        set_value,
  output logic [23:0] edit_value,
  output logic [2:0]  cursor,
  output logic        commit_valid,
  output logic [23:0] commit_data,
  input  logic        commit_ready,
  output logic        step
);

  localparam int unsigned DW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PW = ($clog2(AUTO_PERIOD) < 1) ? 1 : $clog2(AUTO_PERIOD);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(AUTO_PERIOD - 1);

  // Bit map: 0 auto, 1 continue, 2 right, 3 left, 4 down, 5 up, 6 set
  logic [6:0]    raw;
  logic [6:0]    sync1_q, sync2_q;
  logic [6:0]    deb_q, deb_dly_q;
  logic [DW-1:0] dcnt_q [7];
  logic [6:1]    press_q;

  assign raw = {set_value, up_down, left_right, continue0, auto_manual};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      press_q   <= '0;
      for (int unsigned i = 0; i < 7; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      press_q   <= deb_q[6:1] & ~deb_dly_q[6:1];
      for (int unsigned i = 0; i < 7; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DB_LAST) begin
          deb_q[i]  <= ~deb_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic p_cont, p_right, p_left, p_down, p_up, p_set;
  assign p_cont  = press_q[1];
  assign p_right = press_q[2];
  assign p_left  = press_q[3];
  assign p_down  = press_q[4];
  assign p_up    = press_q[5];
  assign p_set   = press_q[6];

  logic [23:0] edit_q, edit_d;
  logic [2:0]  cursor_q, cursor_d;

  // Digit edit indexes with the pre-move cursor so simultaneous move+edit hits the old digit.
  always_comb begin
    edit_d   = edit_q;
    cursor_d = cursor_q;
    for (int unsigned k = 0; k < 6; k++) begin
      if (3'(k) == cursor_q) begin
        if (p_up && !p_down)
          edit_d[4*k +: 4] = edit_q[4*k +: 4] + 4'd1;
        else if (p_down && !p_up)
          edit_d[4*k +: 4] = edit_q[4*k +: 4] - 4'd1;
      end
    end
    if (p_left && !p_right)
      cursor_d = (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
    else if (p_right && !p_left)
      cursor_d = (cursor_q == 3'd0) ? 3'd5 : cursor_q - 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edit_q   <= '0;
      cursor_q <= '0;
    end else begin
      edit_q   <= edit_d;
      cursor_q <= cursor_d;
    end
  end

  typedef enum logic {IDLE, PEND} commit_state_e;
  commit_state_e state_q;
  logic          commit_valid_q;
  logic [23:0]   commit_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      commit_valid_q <= 1'b0;
      commit_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p_set) begin
            commit_data_q  <= edit_q;
            commit_valid_q <= 1'b1;
            state_q        <= PEND;
          end
        end
        PEND: begin
          if (commit_valid_q && commit_ready) begin
            commit_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [PW-1:0] per_q;
  logic          step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_q  <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (deb_q[0] != deb_dly_q[0]) begin
        per_q <= '0;
      end else if (deb_q[0]) begin
        if (per_q == PER_LAST) begin
          per_q  <= '0;
          step_q <= 1'b1;
        end else begin
          per_q <= per_q + 1'b1;
        end
      end else begin
        step_q <= p_cont;
      end
    end
  end

  assign edit_value   = edit_q;
  assign cursor       = cursor_q;
  assign commit_valid = commit_valid_q;
  assign commit_data  = commit_data_q;
  assign step         = step_q;

endmodule

// File: tb/tb_panel_input_ctrl.sv
// Bench for panel_input_ctrl: directed scenarios plus randomized button presses
// checked against a digit-array model of the panel.
module tb_panel_input_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        auto_manual = 1'b0;
  logic        continue0 = 1'b0;
  logic [1:0]  left_right = '0;
  logic [1:0]  up_down = '0;
  logic        set_value = 1'b0;
  logic [23:0] edit_value;
  logic [2:0]  cursor;
  logic        commit_valid;
  logic [23:0] commit_data;
  logic        commit_ready = 1'b0;
  logic        step;

  panel_input_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(10)) dut (
    .clk(clk), .reset(reset), .auto_manual(auto_manual), .continue0(continue0),
    .left_right(left_right), .up_down(up_down), .set_value(set_value),
    .edit_value(edit_value), .cursor(cursor), .commit_valid(commit_valid),
    .commit_data(commit_data), .commit_ready(commit_ready), .step(step)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Step monitor
  int cyc = 0;
  int step_cnt = 0;
  logic prev_step = 1'b0;
  int step_times[$];

  always @(negedge clk) begin
    cyc++;
    if (!reset && step) begin
      check("step_single", {31'b0, prev_step}, 32'd0);
      step_cnt++;
      step_times.push_back(cyc);
    end
    prev_step = step;
  end

  // Reference model: cursor index and an array of digits
  int   m_cur;
  int   m_dig[6];
  bit   m_valid;
  logic [23:0] m_cdata;
  bit   m_auto;
  int   m_steps;

  function automatic logic [23:0] m_edit();
    int v = 0;
    for (int k = 5; k >= 0; k--) v = v * 16 + m_dig[k];
    return 24'(v);
  endfunction

  task automatic model_reset();
    m_cur = 0;
    for (int k = 0; k < 6; k++) m_dig[k] = 0;
    m_valid = 0;
    m_cdata = '0;
    m_auto = 0;
    m_steps = 0;
  endtask

  // mask: [0] continue, [1] right, [2] left, [3] down, [4] up, [5] set
  task automatic model_press(input logic [5:0] mask);
    logic [23:0] old = m_edit();
    if (mask[5] && !m_valid) begin
      m_valid = 1;
      m_cdata = old;
    end
    if (mask[4] != mask[3]) m_dig[m_cur] = (m_dig[m_cur] + (mask[4] ? 1 : 15)) % 16;
    if (mask[2] != mask[1]) m_cur = mask[2] ? (m_cur + 1) % 6 : (m_cur + 5) % 6;
    if (mask[0] && !m_auto) m_steps++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] mask);
    continue0  = mask[0];
    left_right = {mask[2], mask[1]};
    up_down    = {mask[4], mask[3]};
    set_value  = mask[5];
  endtask

  task automatic check_all();
    check("edit_value", {8'b0, edit_value}, {8'b0, m_edit()});
    check("cursor", {29'b0, cursor}, m_cur);
    check("commit_valid", {31'b0, commit_valid}, {31'b0, m_valid});
    check("commit_data", {8'b0, commit_data}, {8'b0, m_cdata});
  endtask

  // Raise at edge 0; action must be absent after edge 6 and present after edge 7.
  task automatic press(input logic [5:0] mask);
    drive(mask);
    tick(7);
    check_all();
    tick(1);
    model_press(mask);
    check_all();
    tick(4);
    drive('0);
    tick(8);
    if (!m_auto) check("step_count", step_cnt, m_steps);
  endtask

  task automatic ready_pulse();
    commit_ready = 1'b1;
    #1;
    check("valid_before_edge", {31'b0, commit_valid}, {31'b0, m_valid});
    tick(1);
    commit_ready = 1'b0;
    m_valid = 0;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive('0);
    auto_manual  = 1'b0;
    commit_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    model_reset();
    step_cnt = 0;
  endtask

  initial begin
    int base;
    logic [5:0] mask;
    model_reset();
    do_reset();
    check_all();
    check("reset_step", {31'b0, step}, 32'd0);

    // Bounce: 3-cycle pulse ignored, then a 12-cycle hold gives exactly one increment
    up_down[1] = 1'b1;
    tick(3);
    up_down[1] = 1'b0;
    tick(15);
    check("bounce_edit", {8'b0, edit_value}, 32'h0);
    press(6'b010000);
    check("debounce_once", {8'b0, edit_value}, 32'h1);

    // Wrap
    do_reset();
    press(6'b000010);
    check("wrap_right", {29'b0, cursor}, 32'd5);
    press(6'b010000);
    press(6'b010000);
    check("wrap_up", {8'b0, edit_value}, 32'h200000);
    press(6'b000100);
    check("wrap_left", {29'b0, cursor}, 32'd0);
    repeat (3) press(6'b001000);
    check("wrap_down", {8'b0, edit_value}, 32'h20000D);

    // Simultaneous
    press(6'b011000);
    press(6'b000110);
    check("simul_edit", {8'b0, edit_value}, 32'h20000D);
    check("simul_cursor", {29'b0, cursor}, 32'd0);

    // Commit handshake
    press(6'b100000);
    check("commit_data", {8'b0, commit_data}, 32'h20000D);
    press(6'b010000);
    check("edit_in_pend", {8'b0, edit_value}, 32'h20000E);
    press(6'b100000);
    check("second_set_drop", {8'b0, commit_data}, 32'h20000D);
    ready_pulse();
    check("handshake_done", {31'b0, commit_valid}, 32'd0);

    // Auto stepping
    auto_manual = 1'b1;
    m_auto = 1;
    tick(8);
    step_times.delete();
    for (int j = 0; j < 6; j++) begin
      tick(4);
      continue0 = 1'b1;
      tick(6);
      continue0 = 1'b0;
      tick(10);
    end
    check("auto_pulses", {31'b0, step_times.size() >= 10}, 32'd1);
    for (int j = 1; j < step_times.size(); j++)
      check("auto_interval", step_times[j] - step_times[j-1], 32'd10);

    // Back to manual
    auto_manual = 1'b0;
    tick(10);
    m_auto = 0;
    base = step_cnt;
    tick(30);
    check("no_timer_step", step_cnt, base);
    m_steps = step_cnt;
    press(6'b000001);
    press(6'b000001);
    check("manual_steps", step_cnt, base + 2);

    // Reset while pending with cursor 3
    repeat (3) press(6'b000100);
    press(6'b100000);
    check("pend_cursor", {29'b0, cursor}, 32'd3);
    check("pend_valid", {31'b0, commit_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_edit", {8'b0, edit_value}, 32'h0);
    check("rst_cursor", {29'b0, cursor}, 32'd0);
    check("rst_valid", {31'b0, commit_valid}, 32'd0);
    check("rst_data", {8'b0, commit_data}, 32'h0);
    check("rst_step", {31'b0, step}, 32'd0);
    do_reset();
    press(6'b100000);
    check("post_rst_commit", {8'b0, commit_data}, 32'h0);
    ready_pulse();

    // Randomized presses against the model
    for (int n = 0; n < 30; n++) begin
      mask = 6'($urandom_range(1, 63));
      press(mask);
      if ($urandom_range(0, 1) == 1) ready_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
